// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU-side request/response signals and the line-wide
// backing-memory signals of the data cache.
//
// Handshake semantics:
//   CPU side   - a request is presented while is_input_valid=1 and completes in
//                the cycle where is_output_valid=1 (hit); addr/mem_rw/din must be
//                held stable until then. is_ready=1 means the cache can evaluate
//                a new request this cycle.
//   Memory side - mem_req is held with stable mem_we/mem_addr/mem_wdata until a
//                single-cycle mem_ack; on a fill, mem_rdata is valid with mem_ack.
//
// Modports:
//   slave  - the cache (receives CPU requests, issues memory requests)
//   master - the environment (CPU pipeline + backing memory)
interface dcache_if;
  // CPU request
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  // CPU response
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  // Backing memory
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  // Statistics
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  modport slave (
    input  is_input_valid, addr, mem_rw, din, mem_rdata, mem_ack,
    output is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output is_input_valid, addr, mem_rw, din, mem_rdata, mem_ack,
    input  is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache between
// the CPU MEM stage and a line-wide backing memory.
//
// Ports:
//   clk        - clock, all state on posedge
//   reset      - asynchronous, active-high
//   bus        - dcache_if.slave: CPU request/response, memory request, counters
//   dbg_state  - current FSM state (0=IDLE, 1=WRITEBACK, 2=ALLOCATE)
//
// Hits complete combinationally in the cycle they are presented. A miss walks
// IDLE -> [WRITEBACK] -> ALLOCATE -> IDLE, after which the held request hits.
module dcache_responder #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  dcache_if.slave    bus,
  output logic [1:0] dbg_state
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - 4 - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   data_d [NUM_SETS];
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic                miss_pending_q, miss_pending_d;
  // Line address of the outstanding miss, captured so the memory transaction
  // does not depend on the CPU holding its inputs once it has been issued.
  logic [27:0]         miss_addr_q, miss_addr_d;

  // Request decode
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       off;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic [31:0]      hit_word;
  logic [1:0]       unused_addr_bits;

  assign idx              = bus.addr[4 +: IDX_W];
  assign req_tag          = bus.addr[31 -: TAG_W];
  assign off              = bus.addr[3:2];
  assign miss_idx         = miss_addr_q[IDX_W-1:0];
  assign miss_tag         = miss_addr_q[27 -: TAG_W];
  assign unused_addr_bits = bus.addr[1:0];

  assign hit      = (state_q == S_IDLE) && bus.is_input_valid &&
                    valid_q[idx] && (tag_q[idx] == req_tag);
  assign hit_word = data_q[idx][{off, 5'b0} +: 32];

  // CPU-facing outputs
  assign bus.is_ready        = (state_q == S_IDLE);
  assign bus.is_hit          = hit;
  assign bus.is_output_valid = hit;
  assign bus.dout            = (hit && !bus.mem_rw) ? hit_word : 32'd0;
  assign bus.hit_count       = hit_cnt_q;
  assign bus.miss_count      = miss_cnt_q;
  assign dbg_state           = state_q;

  // Memory-facing outputs derive purely from state and captured miss address,
  // so they stay stable for as long as mem_req is held.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = '0;
    case (state_q)
      S_WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_q[miss_idx], miss_idx, 4'b0};
        bus.mem_wdata = data_q[miss_idx];
      end
      S_ALLOC: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {miss_addr_q, 4'b0};
      end
      default: ;
    endcase
  end

  // Next-state and array update logic
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    data_d         = data_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    miss_pending_d = miss_pending_q;
    miss_addr_d    = miss_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.is_input_valid) begin
          if (hit) begin
            // The completion of a request that already missed is not a hit.
            if (miss_pending_q) miss_pending_d = 1'b0;
            else                hit_cnt_d      = hit_cnt_q + 32'd1;
            if (bus.mem_rw) begin
              data_d[idx][{off, 5'b0} +: 32] = bus.din;
              dirty_d[idx]                   = 1'b1;
            end
          end else begin
            miss_cnt_d     = miss_cnt_q + 32'd1;
            miss_pending_d = 1'b1;
            miss_addr_d    = bus.addr[31:4];
            state_d        = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_ALLOC;
          end
        end else begin
          // A request abandoned mid-miss leaves nothing to complete.
          miss_pending_d = 1'b0;
        end
      end
      S_WB: begin
        if (bus.mem_ack) begin
          dirty_d[miss_idx] = 1'b0;
          state_d           = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (bus.mem_ack) begin
          data_d[miss_idx]  = bus.mem_rdata;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: asynchronous reset aborts any miss and drops mem_req at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      hit_cnt_q      <= 32'd0;
      miss_cnt_q     <= 32'd0;
      miss_pending_q <= 1'b0;
      miss_addr_q    <= 28'd0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      miss_pending_q <= miss_pending_d;
      miss_addr_q    <= miss_addr_d;
    end
  end

  // Tag and data arrays are qualified by valid bits and need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  dcache_if bus ();

  dcache_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [127:0] mem_model [logic [27:0]];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] din;
    logic        exp_miss;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_dout;
    int          delay;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [31:0] a, input logic [31:0] d,
                              input logic miss, input logic wb, input logic [31:0] wb_a,
                              input logic [31:0] dout, input int delay);
    vec_t v;
    v.rw = rw; v.addr = a; v.din = d; v.exp_miss = miss; v.exp_wb = wb;
    v.exp_wb_addr = wb_a; v.exp_dout = dout; v.delay = delay;
    return v;
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a[31:4])) return mem_model[a[31:4]];
    return '0;
  endfunction

  // Advance one clock: drop any ack pulse just after the edge, then let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #1;
  endtask

  // ---------------- driver: one CPU access incl. memory responder ----------------
  task automatic cpu_access(input vec_t v, input string name);
    int   wait_cnt;
    logic done;
    logic saw_wb;
    wait_cnt = 0;
    done     = 1'b0;
    saw_wb   = 1'b0;
    bus.addr           = v.addr;
    bus.mem_rw         = v.rw;
    bus.din            = v.din;
    bus.is_input_valid = 1'b1;
    #1;
    check({name, " first-cycle hit"}, bus.is_hit, !v.exp_miss);
    check({name, " first-cycle valid"}, bus.is_output_valid, !v.exp_miss);
    for (int c = 0; c < 100 && !done; c++) begin
      if (bus.is_output_valid) begin
        if (!v.rw) check({name, " dout"}, bus.dout, v.exp_dout);
        done = 1'b1;
      end else if (bus.mem_req) begin
        if (wait_cnt == v.delay) begin
          wait_cnt    = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            saw_wb = 1'b1;
            check({name, " wb addr"}, bus.mem_addr, v.exp_wb_addr);
            mem_model[bus.mem_addr[31:4]] = bus.mem_wdata;
          end else begin
            check({name, " fill addr"}, bus.mem_addr, {v.addr[31:4], 4'h0});
            bus.mem_rdata = model_read(bus.mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end
      step();
    end
    bus.is_input_valid = 1'b0;
    check({name, " completed in budget"}, done, 1'b1);
    check({name, " write-back issued"}, saw_wb, v.exp_wb);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] held_addr;
    reset              = 1'b1;
    bus.is_input_valid = 1'b0;
    bus.addr           = '0;
    bus.mem_rw         = 1'b0;
    bus.din            = '0;
    bus.mem_rdata      = '0;
    bus.mem_ack        = 1'b0;

    mem_model[28'h010] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_model[28'h050] = {32'h5003, 32'h5002, 32'h5001, 32'h5000};
    mem_model[28'h031] = {32'h31C, 32'h318, 32'h314, 32'h310};
    mem_model[28'h061] = {32'h61C, 32'h618, 32'h614, 32'h610};

    //                rw    addr           din            miss  wb    wb_addr     dout          delay
    vecs[0]  = mk(1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h0,      32'h1,         3);
    vecs[1]  = mk(1'b1, 32'h0000_0104, 32'hDEAD,      1'b0, 1'b0, 32'h0,      32'h0,         0);
    vecs[2]  = mk(1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'h0,      32'hDEAD,      0);
    vecs[3]  = mk(1'b0, 32'h0000_0500, 32'h0,         1'b1, 1'b1, 32'h100,    32'h5000,      2);
    vecs[4]  = mk(1'b1, 32'h0000_0208, 32'hBEEF,      1'b1, 1'b0, 32'h0,      32'h0,         1);
    vecs[5]  = mk(1'b0, 32'h0000_0208, 32'h0,         1'b0, 1'b0, 32'h0,      32'hBEEF,      0);
    vecs[6]  = mk(1'b0, 32'h0000_0200, 32'h0,         1'b0, 1'b0, 32'h0,      32'h0,         0);
    vecs[7]  = mk(1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b1, 32'h200,    32'hDEAD,      1);
    vecs[8]  = mk(1'b0, 32'h0000_0208, 32'h0,         1'b1, 1'b0, 32'h0,      32'hBEEF,      2);
    vecs[9]  = mk(1'b0, 32'h0000_0310, 32'h0,         1'b1, 1'b0, 32'h0,      32'h310,       0);
    vecs[10] = mk(1'b0, 32'h0000_031C, 32'h0,         1'b0, 1'b0, 32'h0,      32'h31C,       0);
    vecs[11] = mk(1'b1, 32'hFFFF_FFF4, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0,      32'h0,         1);
    vecs[12] = mk(1'b0, 32'hFFFF_FFF4, 32'h0,         1'b0, 1'b0, 32'h0,      32'hA5A5_5A5A, 0);
    vecs[13] = mk(1'b0, 32'hFFFF_FFF7, 32'h0,         1'b0, 1'b0, 32'h0,      32'hA5A5_5A5A, 0);

    #22;
    reset = 1'b0;
    #1;
    check("reset is_ready", bus.is_ready, 1'b1);
    check("reset is_hit", bus.is_hit, 1'b0);
    check("reset is_output_valid", bus.is_output_valid, 1'b0);
    check("reset dout", bus.dout, 32'd0);
    check("reset mem_req", bus.mem_req, 1'b0);
    check("reset hit_count", bus.hit_count, 32'd0);
    check("reset miss_count", bus.miss_count, 32'd0);
    check("reset state", dbg_state, 2'd0);
    step();

    for (int i = 0; i < 14; i++) begin
      cpu_access(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("vec0 miss_count", bus.miss_count, 32'd1);
        check("vec0 hit_count", bus.hit_count, 32'd0);
      end
      if (i == 2) check("vec2 hit_count", bus.hit_count, 32'd2);
    end
    check("table hit_count", bus.hit_count, 32'd7);
    check("table miss_count", bus.miss_count, 32'd7);

    // Long fill stall: memory withholds ack for 20 cycles.
    bus.addr = 32'h400; bus.mem_rw = 1'b0; bus.din = '0; bus.is_input_valid = 1'b1;
    #1;
    check("stall first-cycle hit", bus.is_hit, 1'b0);
    step();
    held_addr = 32'h400;
    for (int c = 0; c < 20; c++) begin
      check("stall is_ready", bus.is_ready, 1'b0);
      check("stall mem_req", bus.mem_req, 1'b1);
      check("stall mem_addr", bus.mem_addr, held_addr);
      step();
    end
    bus.mem_rdata = {32'h40C, 32'h408, 32'h404, 32'h400};
    bus.mem_ack   = 1'b1;
    step();
    check("stall completion valid", bus.is_output_valid, 1'b1);
    check("stall completion dout", bus.dout, 32'h400);
    step();
    bus.is_input_valid = 1'b0;
    check("stall hit_count", bus.hit_count, 32'd7);
    check("stall miss_count", bus.miss_count, 32'd8);

    // Stray ack while idle must be ignored.
    bus.mem_ack = 1'b1;
    step();
    check("stray ack is_ready", bus.is_ready, 1'b1);
    check("stray ack state", dbg_state, 2'd0);
    check("stray ack mem_req", bus.mem_req, 1'b0);
    check("stray ack hit_count", bus.hit_count, 32'd7);
    check("stray ack miss_count", bus.miss_count, 32'd8);

    // Store request abandoned mid-miss: fill completes, store data is not merged.
    bus.addr = 32'h610; bus.mem_rw = 1'b1; bus.din = 32'h1234; bus.is_input_valid = 1'b1;
    step();
    check("abandon in alloc", bus.mem_req, 1'b1);
    bus.is_input_valid = 1'b0;
    bus.mem_rdata = model_read(32'h610);
    bus.mem_ack   = 1'b1;
    step();
    check("abandon back to idle", bus.is_ready, 1'b1);
    check("abandon mem_req low", bus.mem_req, 1'b0);
    cpu_access(mk(1'b0, 32'h610, 32'h0, 1'b0, 1'b0, 32'h0, 32'h610, 0), "abandon reload");

    // Reset while a fill is outstanding.
    bus.addr = 32'h700; bus.mem_rw = 1'b0; bus.is_input_valid = 1'b1;
    step();
    check("rst-miss mem_req before", bus.mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst-miss mem_req async", bus.mem_req, 1'b0);
    check("rst-miss is_ready", bus.is_ready, 1'b1);
    check("rst-miss hit_count", bus.hit_count, 32'd0);
    check("rst-miss miss_count", bus.miss_count, 32'd0);
    bus.is_input_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    cpu_access(vecs[0], "post-reset reload");
    check("post-reset miss_count", bus.miss_count, 32'd1);
    check("post-reset hit_count", bus.hit_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
